// File: rtl/cgol_gen.sv
// Conway's Game of Life generation engine.
// The current generation lives in cur; COMPUTE sweeps one row per cycle into nxt.
// COMMIT then swaps the whole generation in at once, so the display never shows
// a half-updated board. The display scanner runs freely, one row per cycle.

// One cell's birth/survival rule, given its eight neighbours.
module cgol_cell (
    input  logic [7:0] nbr_i,
    input  logic       alive_i,
    output logic       next_o
);
    logic [3:0] cnt;

    // Population count of the neighbourhood (0..8) feeding the B3/S23 rule.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + 4'(nbr_i[i]);
        end
        next_o = (cnt == 4'd3) || (alive_i && (cnt == 4'd2));
    end
endmodule

module cgol_gen #(
    parameter int WIDTH   = 8,
    parameter int HEIGHT  = 8,
    parameter int REGBITS = 3
) (
    input  logic               ph1,
    input  logic               reset_n,
    input  logic               load_en,
    input  logic [REGBITS-1:0] load_addr,
    input  logic [WIDTH-1:0]   load_data,
    input  logic               wrap_mode,
    input  logic               start,
    input  logic               run,
    output logic               busy,
    output logic               done,
    output logic [15:0]        gen_count,
    output logic               still,
    output logic               extinct,
    output logic [HEIGHT-1:0]  row,
    output logic [WIDTH-1:0]   col
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPUTE = 2'd1;
    localparam logic [1:0] S_COMMIT  = 2'd2;

    localparam logic [REGBITS-1:0] LAST_ROW = REGBITS'(HEIGHT - 1);

    logic [1:0]                   state_q, state_d;
    logic [REGBITS-1:0]           rcnt_q;
    logic                         wrap_q;
    logic [HEIGHT-1:0][WIDTH-1:0] cur_q;
    logic [HEIGHT-1:0][WIDTH-1:0] nxt_q;
    logic [15:0]                  gen_q;
    logic                         still_q;
    logic                         extinct_q;
    logic                         done_q;
    logic [REGBITS-1:0]           scan_q;

    logic                         addr_ok;
    logic                         do_load;
    logic [REGBITS-1:0]           up_idx, dn_idx;
    logic [WIDTH-1:0]             up_row, mid_row, dn_row;
    logic [WIDTH+1:0]             up_ext, mid_ext, dn_ext;
    logic [WIDTH-1:0]             row_next;

    // Out-of-range row addresses are dropped; loads only land while idle.
    assign addr_ok = (int'(load_addr) < HEIGHT);
    assign do_load = (state_q == S_IDLE) && load_en && addr_ok;

    // Gather the three source rows around the row being computed. At the top and
    // bottom edges the missing row either wraps round or reads as all-dead.
    always_comb begin
        up_idx  = (rcnt_q == '0)       ? LAST_ROW : rcnt_q - REGBITS'(1);
        dn_idx  = (rcnt_q == LAST_ROW) ? '0       : rcnt_q + REGBITS'(1);
        mid_row = cur_q[rcnt_q];
        up_row  = ((rcnt_q == '0) && !wrap_q)       ? '0 : cur_q[up_idx];
        dn_row  = ((rcnt_q == LAST_ROW) && !wrap_q) ? '0 : cur_q[dn_idx];
        // ext[k] holds column k-1; the two pad bits are the left/right edge neighbours.
        up_ext  = {wrap_q ? up_row[0]  : 1'b0, up_row,  wrap_q ? up_row[WIDTH-1]  : 1'b0};
        mid_ext = {wrap_q ? mid_row[0] : 1'b0, mid_row, wrap_q ? mid_row[WIDTH-1] : 1'b0};
        dn_ext  = {wrap_q ? dn_row[0]  : 1'b0, dn_row,  wrap_q ? dn_row[WIDTH-1]  : 1'b0};
    end

    // One rule evaluator per column; a whole row is produced every cycle.
    for (genvar c = 0; c < WIDTH; c++) begin : g_col
        cgol_cell u_cell (
            .nbr_i   ({up_ext[c+2:c], mid_ext[c+2], mid_ext[c], dn_ext[c+2:c]}),
            .alive_i (mid_ext[c+1]),
            .next_o  (row_next[c])
        );
    end

    // Generation sequencer: a load in the same cycle wins over start/run.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (!load_en && (start || run)) state_d = S_COMPUTE;
            S_COMPUTE: if (rcnt_q == LAST_ROW)         state_d = S_COMMIT;
            S_COMMIT:  state_d = run ? S_COMPUTE : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // FSM state, row sweep counter and the edge mode held for each generation.
    always_ff @(posedge ph1 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            rcnt_q  <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_COMPUTE && rcnt_q != LAST_ROW) begin
                rcnt_q <= rcnt_q + REGBITS'(1);
            end else begin
                rcnt_q <= '0;
            end
            if (state_q != S_COMPUTE && state_d == S_COMPUTE) begin
                wrap_q <= wrap_mode;
            end
        end
    end

    // Board storage: cur changes only on a load or on commit.
    always_ff @(posedge ph1 or negedge reset_n) begin
        if (!reset_n) begin
            cur_q <= '0;
            nxt_q <= '0;
        end else begin
            if (do_load) begin
                cur_q[load_addr] <= load_data;
            end
            if (state_q == S_COMPUTE) begin
                nxt_q[rcnt_q] <= row_next;
            end
            if (state_q == S_COMMIT) begin
                cur_q <= nxt_q;
            end
        end
    end

    // Per-generation status, updated together with the commit.
    always_ff @(posedge ph1 or negedge reset_n) begin
        if (!reset_n) begin
            gen_q     <= '0;
            still_q   <= 1'b0;
            extinct_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= (state_q == S_COMMIT);
            if (state_q == S_COMMIT) begin
                gen_q     <= gen_q + 16'd1;
                still_q   <= (nxt_q == cur_q);
                extinct_q <= (nxt_q == '0);
            end
        end
    end

    // Free-running display row scanner.
    always_ff @(posedge ph1 or negedge reset_n) begin
        if (!reset_n) begin
            scan_q <= '0;
        end else if (scan_q == LAST_ROW) begin
            scan_q <= '0;
        end else begin
            scan_q <= scan_q + REGBITS'(1);
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign gen_count = gen_q;
    assign still     = still_q;
    assign extinct   = extinct_q;
    assign row       = HEIGHT'(1) << scan_q;
    assign col       = cur_q[scan_q];
endmodule

// File: tb/tb_cgol_gen.sv
// Self-checking bench for cgol_gen: directed patterns plus random boards, checked
// against a straightforward neighbour-counting Life model.
module tb_cgol_gen;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int RB = 3;

    typedef logic [H-1:0][W-1:0] grid_t;

    logic          ph1;
    logic          reset_n;
    logic          load_en;
    logic [RB-1:0] load_addr;
    logic [W-1:0]  load_data;
    logic          wrap_mode;
    logic          start;
    logic          run;
    logic          busy;
    logic          done;
    logic [15:0]   gen_count;
    logic          still;
    logic          extinct;
    logic [H-1:0]  row;
    logic [W-1:0]  col;

    int n_cmp = 0;
    int n_err = 0;

    cgol_gen #(.WIDTH(W), .HEIGHT(H), .REGBITS(RB)) dut (
        .ph1       (ph1),
        .reset_n   (reset_n),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .wrap_mode (wrap_mode),
        .start     (start),
        .run       (run),
        .busy      (busy),
        .done      (done),
        .gen_count (gen_count),
        .still     (still),
        .extinct   (extinct),
        .row       (row),
        .col       (col)
    );

    initial ph1 = 1'b0;
    always #5 ph1 = ~ph1;

    // Reference Life step: count neighbours directly with index arithmetic.
    function automatic grid_t life(input grid_t g, input bit wrap);
        grid_t n;
        int cnt, rr, cc;
        n = '0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr == 0 && dc == 0) continue;
                        rr = r + dr;
                        cc = c + dc;
                        if (wrap) begin
                            rr = (rr + H) % H;
                            cc = (cc + W) % W;
                        end else if (rr < 0 || rr >= H || cc < 0 || cc >= W) begin
                            continue;
                        end
                        cnt += int'(g[rr][cc]);
                    end
                end
                n[r][c] = (cnt == 3) || (g[r][c] && cnt == 2);
            end
        end
        return n;
    endfunction

    task automatic tick;
        @(posedge ph1);
        #1;
    endtask

    task automatic apply_reset;
        reset_n = 1'b0;
        load_en = 1'b0;
        start   = 1'b0;
        run     = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic load_row(input int a, input logic [W-1:0] d);
        load_en   = 1'b1;
        load_addr = RB'(a);
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic load_grid(input grid_t g);
        for (int r = 0; r < H; r++) load_row(r, g[r]);
    endtask

    // Reassemble the board from one full display scan.
    task automatic read_grid(output grid_t g);
        g = '0;
        for (int i = 0; i < H; i++) begin
            for (int r = 0; r < H; r++) if (row[r]) g[r] = col;
            tick();
        end
    endtask

    // Bounded wait for done; cyc is the edge count, or -1 on timeout.
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (done === 1'b1) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic do_step(output int cyc);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(cyc);
    endtask

    task automatic test_reset;
        grid_t g;
        load_en = 1'b0; start = 1'b0; run = 1'b0; wrap_mode = 1'b0;
        load_addr = '0; load_data = '0;
        reset_n = 1'b0;
        #3;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (gen_count !== 16'd0) begin n_err++; $display("FAIL reset_gen: got %0d want 0", gen_count); end
        n_cmp++; if ({still, extinct} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b want 00", {still, extinct}); end
        n_cmp++; if (row !== H'(1)) begin n_err++; $display("FAIL reset_row: got %h want 01", row); end
        n_cmp++; if (col !== '0) begin n_err++; $display("FAIL reset_col: got %h want 00", col); end
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        read_grid(g);
        n_cmp++; if (g !== '0) begin n_err++; $display("FAIL reset_grid: got %h want 0", g); end
    endtask

    task automatic test_blinker;
        grid_t g, e, got;
        int cyc;
        apply_reset();
        g = '0; g[3] = 8'h1C;
        load_grid(g);
        wrap_mode = 1'b0;
        do_step(cyc);
        n_cmp++; if (cyc != 9) begin n_err++; $display("FAIL blinker_latency: got %0d want 9", cyc); end
        n_cmp++; if (gen_count !== 16'd1) begin n_err++; $display("FAIL blinker_gen: got %0d want 1", gen_count); end
        n_cmp++; if ({still, extinct} !== 2'b00) begin n_err++; $display("FAIL blinker_flags: got %b want 00", {still, extinct}); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL blinker_done_width: got %b want 0", done); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL blinker_busy: got %b want 0", busy); end
        e = '0; e[2] = 8'h08; e[3] = 8'h08; e[4] = 8'h08;
        read_grid(got);
        n_cmp++; if (got !== e) begin n_err++; $display("FAIL blinker_grid: got %h want %h", got, e); end
        n_cmp++; if (got !== life(g, 1'b0)) begin n_err++; $display("FAIL blinker_model: got %h want %h", got, life(g, 1'b0)); end
    endtask

    task automatic test_still_life;
        grid_t g, got;
        int cyc;
        apply_reset();
        g = '0; g[3] = 8'h18; g[4] = 8'h18;
        load_grid(g);
        wrap_mode = 1'b0;
        do_step(cyc);
        n_cmp++; if ({still, extinct} !== 2'b10) begin n_err++; $display("FAIL still_flags: got %b want 10", {still, extinct}); end
        read_grid(got);
        n_cmp++; if (got !== g) begin n_err++; $display("FAIL still_grid: got %h want %h", got, g); end
        // A load must not disturb generation status.
        load_row(0, 8'hFF);
        tick();
        n_cmp++; if ({still, extinct} !== 2'b10) begin n_err++; $display("FAIL load_keeps_flags: got %b want 10", {still, extinct}); end
        n_cmp++; if (gen_count !== 16'd1) begin n_err++; $display("FAIL load_keeps_gen: got %0d want 1", gen_count); end
    endtask

    task automatic test_corners;
        grid_t g, e, got;
        int cyc;
        apply_reset();
        g = '0; g[0] = 8'h81; g[7] = 8'h01;
        load_grid(g);
        wrap_mode = 1'b1;
        do_step(cyc);
        e = '0; e[0] = 8'h81; e[7] = 8'h81;
        read_grid(got);
        n_cmp++; if (got !== e) begin n_err++; $display("FAIL corners_wrap: got %h want %h", got, e); end
        load_grid(g);
        wrap_mode = 1'b0;
        do_step(cyc);
        read_grid(got);
        n_cmp++; if (got !== '0) begin n_err++; $display("FAIL corners_nowrap: got %h want 0", got); end
        n_cmp++; if ({still, extinct} !== 2'b01) begin n_err++; $display("FAIL corners_extinct: got %b want 01", {still, extinct}); end
        n_cmp++; if (gen_count !== 16'd2) begin n_err++; $display("FAIL corners_gen: got %0d want 2", gen_count); end
    endtask

    task automatic test_glider_run;
        grid_t g, m, got;
        int cyc, extra;
        apply_reset();
        g = '0; g[0] = 8'h02; g[1] = 8'h04; g[2] = 8'h07;
        load_grid(g);
        m = g;
        wrap_mode = 1'b1;
        run = 1'b1;
        tick();
        for (int n = 1; n <= 32; n++) begin
            wait_done(cyc);
            m = life(m, 1'b1);
            n_cmp++; if (cyc != 9) begin n_err++; $display("FAIL glider_period gen %0d: got %0d want 9", n, cyc); end
            if (n == 31) run = 1'b0;
        end
        extra = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        n_cmp++; if (extra != 0) begin n_err++; $display("FAIL glider_stop: got %0d busy/done cycles want 0", extra); end
        n_cmp++; if (gen_count !== 16'd32) begin n_err++; $display("FAIL glider_gen: got %0d want 32", gen_count); end
        read_grid(got);
        n_cmp++; if (got !== g) begin n_err++; $display("FAIL glider_return: got %h want %h", got, g); end
        n_cmp++; if (got !== m) begin n_err++; $display("FAIL glider_model: got %h want %h", got, m); end
    endtask

    task automatic test_busy_ignore;
        grid_t g, e, got;
        int cyc, extra;
        apply_reset();
        for (int r = 0; r < H; r++) g[r] = W'($urandom);
        wrap_mode = 1'($urandom);
        e = life(g, wrap_mode);
        load_grid(g);
        start = 1'b1; tick(); start = 1'b0;
        repeat (3) tick();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL busy_high: got %b want 1", busy); end
        load_en = 1'b1; load_addr = RB'($urandom); load_data = ~g[load_addr]; start = 1'b1;
        tick();
        load_en = 1'b0; start = 1'b0;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        wait_done(cyc);
        n_cmp++; if (cyc != 3) begin n_err++; $display("FAIL busy_done_time: got %0d want 3", cyc); end
        extra = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        n_cmp++; if (extra != 0) begin n_err++; $display("FAIL busy_no_queue: got %0d busy/done cycles want 0", extra); end
        n_cmp++; if (gen_count !== 16'd1) begin n_err++; $display("FAIL busy_gen: got %0d want 1", gen_count); end
        read_grid(got);
        n_cmp++; if (got !== e) begin n_err++; $display("FAIL busy_grid: got %h want %h", got, e); end
    endtask

    task automatic test_random;
        grid_t m, nm, got;
        int cyc;
        apply_reset();
        m = '0;
        for (int it = 0; it < 8; it++) begin
            if (it % 2 == 0) begin
                for (int r = 0; r < H; r++) m[r] = W'($urandom) & W'($urandom | $urandom);
                load_grid(m);
            end
            wrap_mode = 1'($urandom);
            nm = life(m, wrap_mode);
            do_step(cyc);
            n_cmp++; if (cyc != 9) begin n_err++; $display("FAIL rand_latency it %0d: got %0d want 9", it, cyc); end
            n_cmp++; if (still !== 1'(nm == m)) begin n_err++; $display("FAIL rand_still it %0d: got %b want %b", it, still, nm == m); end
            n_cmp++; if (extinct !== 1'(nm == '0)) begin n_err++; $display("FAIL rand_extinct it %0d: got %b want %b", it, extinct, nm == '0); end
            n_cmp++; if (gen_count !== 16'(it + 1)) begin n_err++; $display("FAIL rand_gen it %0d: got %0d want %0d", it, gen_count, it + 1); end
            read_grid(got);
            n_cmp++; if (got !== nm) begin n_err++; $display("FAIL rand_grid it %0d: got %h want %h", it, got, nm); end
            m = nm;
        end
    endtask

    task automatic test_load_start;
        grid_t got;
        int extra;
        apply_reset();
        load_en = 1'b1; load_addr = 3'd5; load_data = 8'hA5; start = 1'b1;
        tick();
        load_en = 1'b0; start = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL loadstart_busy: got %b want 0", busy); end
        extra = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done === 1'b1) extra++;
        end
        n_cmp++; if (extra != 0) begin n_err++; $display("FAIL loadstart_done: got %0d pulses want 0", extra); end
        read_grid(got);
        n_cmp++; if (got[5] !== 8'hA5) begin n_err++; $display("FAIL loadstart_row: got %h want a5", got[5]); end
        n_cmp++; if (gen_count !== 16'd0) begin n_err++; $display("FAIL loadstart_gen: got %0d want 0", gen_count); end
    endtask

    task automatic test_display;
        grid_t g;
        int idx, prev, bad_hot, bad_seq, bad_col;
        apply_reset();
        for (int r = 0; r < H; r++) g[r] = W'($urandom);
        load_grid(g);
        wrap_mode = 1'b1;
        prev = -1; bad_hot = 0; bad_seq = 0; bad_col = 0;
        start = 1'b1; tick(); start = 1'b0;
        // While computing, the display must keep showing the old board.
        for (int k = 0; k < H; k++) begin
            idx = -1;
            for (int r = 0; r < H; r++) if (row[r]) idx = r;
            if (!$onehot(row)) bad_hot++;
            if (prev >= 0 && idx != (prev + 1) % H) bad_seq++;
            if (idx >= 0 && col !== g[idx]) bad_col++;
            prev = idx;
            tick();
        end
        n_cmp++; if (bad_hot != 0) begin n_err++; $display("FAIL disp_onehot: got %0d bad cycles want 0", bad_hot); end
        n_cmp++; if (bad_seq != 0) begin n_err++; $display("FAIL disp_advance: got %0d bad steps want 0", bad_seq); end
        n_cmp++; if (bad_col != 0) begin n_err++; $display("FAIL disp_stable: got %0d bad cols want 0", bad_col); end
        repeat (4) tick();
    endtask

    task automatic test_reset_mid;
        grid_t g, got;
        int cyc, extra;
        apply_reset();
        g = '0; g[3] = 8'h18; g[4] = 8'h18;
        load_grid(g);
        wrap_mode = 1'b0;
        do_step(cyc);
        start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_before: got %b want 1", busy); end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL mid_busy_done: got %b want 00", {busy, done}); end
        n_cmp++; if (gen_count !== 16'd0) begin n_err++; $display("FAIL mid_gen: got %0d want 0", gen_count); end
        n_cmp++; if ({still, extinct} !== 2'b00) begin n_err++; $display("FAIL mid_flags: got %b want 00", {still, extinct}); end
        n_cmp++; if (row !== H'(1) || col !== '0) begin n_err++; $display("FAIL mid_display: got row %h col %h want 01/00", row, col); end
        tick();
        reset_n = 1'b1;
        extra = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        n_cmp++; if (extra != 0) begin n_err++; $display("FAIL mid_quiet: got %0d busy/done cycles want 0", extra); end
        read_grid(got);
        n_cmp++; if (got !== '0) begin n_err++; $display("FAIL mid_cleared: got %h want 0", got); end
        g = '0; g[3] = 8'h1C;
        load_grid(g);
        do_step(cyc);
        n_cmp++; if (cyc != 9) begin n_err++; $display("FAIL mid_restart_latency: got %0d want 9", cyc); end
        n_cmp++; if (gen_count !== 16'd1) begin n_err++; $display("FAIL mid_restart_gen: got %0d want 1", gen_count); end
        read_grid(got);
        n_cmp++; if (got !== life(g, 1'b0)) begin n_err++; $display("FAIL mid_restart_grid: got %h want %h", got, life(g, 1'b0)); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_blinker();
        test_still_life();
        test_corners();
        test_glider_run();
        test_busy_ignore();
        test_random();
        test_load_start();
        test_display();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cgol_gen.md
CGOL_GEN -- requirements
Module: cgol_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of columns (cells per row), legal range 3..64.
REQ-002 SHALL have parameter HEIGHT, default 8, number of rows, legal range 3..64.
REQ-003 SHALL have parameter REGBITS, default 3, row-address width, equal to clog2(HEIGHT).
REQ-004 SHALL have ph1  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have reset_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have load_en  input  1  write load_data into state row load_addr this cycle.
REQ-007 SHALL have load_addr  input  REGBITS  row index to load; values >= HEIGHT are ignored.
REQ-008 SHALL have load_data  input  WIDTH  row pattern; bit c = column c, 1 = alive.
REQ-009 SHALL have wrap_mode  input  1  1 = toroidal edges, 0 = out-of-array cells dead.
REQ-010 SHALL have start  input  1  request one generation step.
REQ-011 SHALL have run  input  1  free-run: chain generations back to back while high.
REQ-012 SHALL have busy  output  1  high in COMPUTE and COMMIT.
REQ-013 SHALL have done  output  1  one-cycle pulse when a new generation is committed.
REQ-014 SHALL have gen_count  output  16  generations committed since reset.
REQ-015 SHALL have still  output  1  last committed generation equalled its predecessor.
REQ-016 SHALL have extinct  output  1  last committed generation had zero live cells.
REQ-017 SHALL have row  output  HEIGHT  one-hot display row select.
REQ-018 SHALL have col  output  WIDTH  live-cell pattern of the selected row.

Function
REQ-019 SHALL hold a current-state array cur[HEIGHT][WIDTH] and a next-state array nxt[HEIGHT][WIDTH].
REQ-020 SHALL implement FSM IDLE -> COMPUTE -> COMMIT -> IDLE, with COMMIT -> COMPUTE when run=1.
REQ-021 In IDLE, start=1 or run=1 SHALL enter COMPUTE next cycle and latch wrap_mode for the whole generation.
REQ-022 COMPUTE SHALL last exactly HEIGHT cycles, row counter 0..HEIGHT-1, writing nxt[r] from cur rows r-1, r, r+1.
REQ-023 Next cell state SHALL be 1 iff live-neighbour count == 3, or cell alive and count == 2; the count uses 4 bits, range 0..8.
REQ-024 With wrap latched 1, neighbour indices SHALL wrap modulo HEIGHT and WIDTH; with wrap latched 0, out-of-range neighbours SHALL count as dead.
REQ-025 COMMIT SHALL copy nxt to cur, increment gen_count (0xFFFF wraps to 0), update still and extinct, and pulse done, all in one cycle.
REQ-026 Latency from the start-accept edge to the done pulse SHALL be HEIGHT+1 cycles; back-to-back period in run mode SHALL be HEIGHT+1 cycles.
REQ-027 load_en SHALL write cur[load_addr] only in IDLE; while busy it SHALL be ignored with no side effects.
REQ-028 load_en and start together in IDLE: the load SHALL take effect and start SHALL be ignored that cycle.
REQ-029 start while busy SHALL be ignored (no queuing); dropping run mid-generation SHALL finish the current generation, then return to IDLE.
REQ-030 Loads SHALL NOT change gen_count, still or extinct.
REQ-031 Display SHALL scan free-running: row one-hot advances one row per cycle, HEIGHT-1 wraps to 0, col = cur[selected row], independent of FSM state.
REQ-032 cur SHALL only change on load or COMMIT, so col never shows a partially computed generation.

Reset
REQ-033 reset_n low SHALL asynchronously force: FSM IDLE, cur and nxt all 0, gen_count 0, busy 0, done 0, still 0, extinct 0, row = 1 (row 0), col 0.
REQ-034 Reset asserted mid-COMPUTE or mid-COMMIT SHALL abort the generation; no done pulse, and the FSM is in IDLE at the first edge after release.

Verification
REQ-035 Blinker: 8x8, load row 3 = 0x1C, wrap 0, start -> done at cycle 9; rows 2,3,4 = 0x08 each; gen_count=1; still=0.
REQ-036 Still-life: 2x2 block at rows 3-4 = 0x18, start -> cur unchanged, still=1, extinct=0.
REQ-037 Corners: alive (0,0),(0,7),(7,0); wrap 1 -> (7,7) born, all four alive; repeat with wrap 0 -> all die, extinct=1.
REQ-038 Glider on 8x8 with wrap 1, run high 32 generations -> pattern identical to the loaded one; gen_count=32; done pulses exactly every 9 cycles.
REQ-039 Load while busy and start while busy -> both ignored; final state matches an undisturbed run.
REQ-040 reset_n low at COMPUTE row 4 -> all outputs at reset values immediately; no done pulse; a fresh load+start then behaves normally.
